uart_rx_fifo: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver. Adds runtime-selectable data width, parity and stop bits, plus start-bit validation, framing, parity and overrun detection. Received words, with their per-word error flags, are buffered in an internal show-ahead FIFO. The consumer drains the FIFO over a valid/ready handshake. Sits between the pad-side RX line and the SoC bus peripheral register block.

---
 rtl/uart_rx_fifo_pkg.sv | 12 +
 rtl/uart_rx_fifo_if.sv | 21 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 50 +++++
 rtl/uart_rx_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_pkg: shared types and constants for the parametrised UART receiver
//   rx_state_t      receiver FSM states
//   parity_t        decoded parity mode
//   UART_MIN_BAUD_DIV smallest usable bit period minus one
package uart_pkg;
  localparam int UART_MIN_BAUD_DIV = 7;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} rx_state_t;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  function automatic parity_t decode_parity(input logic [1:0] p);
    return p == 2'd1 ? PAR_EVEN : p == 2'd2 ? PAR_ODD : PAR_NONE;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: consumer-side stream of received words plus FIFO status
//   data_o/perr_o/ferr_o  head word and its error flags
//   vld_o/rdy_i           pop handshake
//   ovr_o/ovr_clr_i       sticky overrun flag and its clear
//   level_o               FIFO occupancy
interface uart_rx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic [DATA_W-1:0] data_o;
  logic              perr_o;
  logic              ferr_o;
  logic              vld_o;
  logic              rdy_i;
  logic              ovr_o;
  logic              ovr_clr_i;
  logic [LW-1:0]     level_o;
  modport master (output data_o, perr_o, ferr_o, vld_o, ovr_o, level_o, input rdy_i, ovr_clr_i);
  modport slave (input data_o, perr_o, ferr_o, vld_o, ovr_o, level_o, output rdy_i, ovr_clr_i);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with occupancy count
//   push_i/din_i   write; ignored when full unless a pop happens the same cycle
//   pop_i/dout_o   pop; dout_o shows the head word, zero when empty
//   full_o/empty_o/level_o  status
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_en, rd_en;
  always_comb begin
    full_o   = level_q == (AW+1)'(DEPTH);
    empty_o  = level_q == '0;
    rd_en    = pop_i & ~empty_o;
    // a pop frees the slot the simultaneous push lands in
    wr_en    = push_i & (~full_o | rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    dout_o   = empty_o ? '0 : mem[rd_ptr_q];
    level_o  = level_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with runtime frame format and buffered output
//   clk_i/rst_i   clock, asynchronous active-high reset
//   rx_i          serial input, idle high
//   baud_div_i    bit period minus 1 in clk_i cycles
//   data_bits_i   data bits per frame, out-of-range clamps to DATA_W
//   parity_i      0/3 none, 1 even, 2 odd
//   stop2_i       check a second stop bit
//   busy_o        receiver is inside a frame
//   bus           received-word stream, overrun flag and FIFO level
// UART_RX_MAJORITY_EN: bit decisions use a 2-of-3 vote around mid-bit
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rx_i,
  input  logic [31:0]        baud_div_i,
  input  logic [3:0]         data_bits_i,
  input  logic [1:0]         parity_i,
  input  logic               stop2_i,
  output logic               busy_o,
  uart_rx_fifo_if.master     bus
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  rx_state_t              state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [3:0]             bcnt_q, bcnt_d;
  logic [DATA_W-1:0]      sh_q, sh_d;
  logic [31:0]            baud_q, baud_d;
  logic [3:0]             nbits_q, nbits_d;
  parity_t                par_q, par_d;
  logic                   stop2_q, stop2_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;
  logic                   ovr_q, ovr_d;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]             smp_q, smp_d;
`else
  logic                   smp_q, smp_d;
`endif
  logic                   rx_s, bit_v, tick, push, pop;
  logic [31:0]            dec_pt;
  logic [3:0]             nb;
  logic [DATA_W+1:0]      wdata, fifo_dout;
  logic                   fifo_full, fifo_empty;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign pop  = bus.vld_o & bus.rdy_i;
  sync_fifo #(.W(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (wdata),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (bus.level_o)
  );
  assign bus.vld_o = ~fifo_empty;
  assign {bus.perr_o, bus.ferr_o, bus.data_o} = fifo_dout;
  assign bus.ovr_o = ovr_q;
  assign busy_o    = busy_q;
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx_i};
    rx_prev_d = rx_s;
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    bcnt_d    = bcnt_q;
    sh_d      = sh_q;
    baud_d    = baud_q;
    nbits_d   = nbits_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    push      = 1'b0;
    nb        = (data_bits_i < 4'd5 || data_bits_i > 4'(DATA_W)) ? 4'(DATA_W) : data_bits_i;
    // every bit resolves one cycle past mid: START counts from the edge, later bits
    // count whole periods from the previous decision
    dec_pt    = state_q == START ? (baud_q >> 1) + 32'd1 : baud_q;
    tick      = cnt_q == dec_pt;
`ifdef UART_RX_MAJORITY_EN
    smp_d     = {smp_q[0], rx_s};
    bit_v     = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);
`else
    smp_d     = rx_s;
    bit_v     = smp_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q & ~rx_s) begin
          state_d = START;
          bcnt_d  = '0;
          sh_d    = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          baud_d  = baud_div_i < UART_MIN_BAUD_DIV ? 32'(UART_MIN_BAUD_DIV) : baud_div_i;
          nbits_d = nb;
          par_d   = decode_parity(parity_i);
          stop2_d = stop2_i;
        end
      end
      START: if (tick) begin
        state_d = bit_v ? IDLE : DATA;
        cnt_d   = '0;
      end
      DATA: if (tick) begin
        cnt_d  = '0;
        sh_d   = sh_q | (DATA_W'(bit_v) << bcnt_q);
        bcnt_d = bcnt_q + 4'd1;
        if (bcnt_q == nbits_q - 4'd1) state_d = par_q == PAR_NONE ? STOP1 : PARITY;
      end
      PARITY: if (tick) begin
        cnt_d   = '0;
        perr_d  = ^sh_q ^ bit_v ^ (par_q == PAR_ODD);
        state_d = STOP1;
      end
      STOP1: if (tick) begin
        cnt_d   = '0;
        ferr_d  = ferr_q | ~bit_v;
        push    = ~stop2_q;
        state_d = stop2_q ? STOP2 : IDLE;
      end
      STOP2: if (tick) begin
        cnt_d   = '0;
        ferr_d  = ferr_q | ~bit_v;
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wdata  = {perr_q, ferr_d, sh_q};
    busy_d = state_d != IDLE;
    // a drop wins over a same-cycle clear
    ovr_d  = (push & fifo_full & ~pop) | (ovr_q & ~bus.ovr_clr_i);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      smp_q     <= '1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      sh_q      <= '0;
      baud_q    <= '0;
      nbits_q   <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      smp_q     <= smp_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      sh_q      <= sh_d;
      baud_q    <= baud_d;
      nbits_q   <= nbits_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames checked against a queue model
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  logic        clk, rst, rx, stop2, busy;
  logic [31:0] baud_div;
  logic [3:0]  data_bits;
  logic [1:0]  parity;
  int          total, bad;
  bit          rdy_hold, m_ovr, busy_seen;
  logic [9:0]  mq[$];
  logic [9:0]  got[$];
  uart_rx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) bus ();
  uart_rx_fifo dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .baud_div_i  (baud_div),
    .data_bits_i (data_bits),
    .parity_i    (parity),
    .stop2_i     (stop2),
    .busy_o      (busy),
    .bus         (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.vld_o && bus.rdy_i) got.push_back({bus.perr_o, bus.ferr_o, bus.data_o});
    if (busy) busy_seen = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int n_eff(input int n);
    return (n < 5 || n > 8) ? 8 : n;
  endfunction
  function automatic logic [9:0] word(input logic [7:0] d, input int n, input int par, input bit st2,
                                      input bit pflip, input bit s1, input bit s2);
    logic [7:0] dm;
    dm = d & 8'((1 << n_eff(n)) - 1);
    return {((par == 1 || par == 2) && pflip), (!s1 || (st2 && !s2)), dm};
  endfunction
  function automatic void mpush(input logic [9:0] w);
    if (mq.size() - got.size() < DEPTH) mq.push_back(w);
    else m_ovr = 1'b1;
  endfunction
  task automatic send_frame(input logic [7:0] d, input int n, input int par, input bit st2,
                            input bit pflip, input bit s1, input bit s2, input int baud,
                            input int glitch, input bit pop_at_push, input bit clr_at_push,
                            input bit scramble);
    logic       bits[$];
    logic [7:0] dm;
    int         per, pc;
    per = baud + 1;
    dm  = d & 8'((1 << n_eff(n)) - 1);
    bits.push_back(1'b0);
    for (int i = 0; i < n_eff(n); i++) bits.push_back(d[i]);
    if (par == 1 || par == 2) bits.push_back(^dm ^ (par == 2) ^ pflip);
    bits.push_back(s1);
    if (st2) bits.push_back(s2);
    pc = 4 + baud / 2 + (bits.size() - 1) * per;
    baud_div  = 32'(baud);
    data_bits = n[3:0];
    parity    = par[1:0];
    stop2     = st2;
    for (int cc = 0; cc < bits.size() * per; cc++) begin
      rx = (cc == glitch) ? 1'b1 : bits[cc / per];
      bus.rdy_i     = rdy_hold | (pop_at_push && cc == pc);
      bus.ovr_clr_i = clr_at_push && cc == pc;
      if (scramble && cc == per) begin
        data_bits = 4'($urandom);
        parity    = 2'($urandom);
        stop2     = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    rx = 1'b1;
    bus.rdy_i = rdy_hold;
    bus.ovr_clr_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic drain(input string tag);
    rdy_hold = 1'b1;
    bus.rdy_i = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #1;
    rdy_hold = 1'b0;
    bus.rdy_i = 1'b0;
    chk({tag, "_vld_after_drain"}, 32'(bus.vld_o), 32'd0);
    chk({tag, "_count"}, 32'(got.size()), 32'(mq.size()));
    for (int i = 0; i < mq.size() && i < got.size(); i++) chk({tag, "_word"}, 32'(got[i]), 32'(mq[i]));
    mq.delete();
    got.delete();
  endtask
  task automatic clear_ovr();
    bus.ovr_clr_i = 1'b1;
    @(posedge clk); #1;
    bus.ovr_clr_i = 1'b0;
    m_ovr = 1'b0;
  endtask
  initial begin
    logic [9:0] exp_w;
    total = 0;
    bad = 0;
    rst = 1'b1;
    rx = 1'b1;
    baud_div = 32'd15;
    data_bits = 4'd8;
    parity = 2'd0;
    stop2 = 1'b0;
    bus.rdy_i = 1'b0;
    bus.ovr_clr_i = 1'b0;
    rdy_hold = 1'b0;
    m_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(bus.vld_o), 0);
    chk("rst_level", 32'(bus.level_o), 0);
    chk("rst_ovr", 32'(bus.ovr_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(bus.data_o), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rdy_hold = 1'b1;
    send_frame(8'hA5, 8, 0, 0, 0, 1, 1, 15, -1, 0, 0, 0);
    mpush(word(8'hA5, 8, 0, 0, 0, 1, 1));
    drain("t1_8n1");
    rdy_hold = 1'b1;
    send_frame(8'h03, 7, 1, 1, 1, 1, 1, 15, -1, 0, 0, 0);
    mpush(word(8'h03, 7, 1, 1, 1, 1, 1));
    send_frame(8'h03, 7, 1, 1, 1, 1, 0, 15, -1, 0, 0, 0);
    mpush(word(8'h03, 7, 1, 1, 1, 1, 0));
    drain("t2_7e2");
    busy_seen = 1'b0;
    baud_div = 32'd15;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t3_busy_pulsed", 32'(busy_seen), 1);
    chk("t3_busy_idle", 32'(busy), 0);
    chk("t3_level", 32'(bus.level_o), 0);
    chk("t3_vld", 32'(bus.vld_o), 0);
    rdy_hold = 1'b1;
    send_frame(8'h00, 8, 0, 0, 0, 1, 1, 15, 1 + 15 / 2 + 3 * 16, 0, 0, 0);
`ifdef UART_RX_MAJORITY_EN
    exp_w = 10'h000;
`else
    exp_w = 10'h004;
`endif
    mq.push_back(exp_w);
    drain("t6_glitch");
    rdy_hold = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 8, 0, 0, 0, 1, 1, 15, -1, 0, 0, 0);
      mpush(word(8'(i), 8, 0, 0, 0, 1, 1));
    end
    chk("t4_level_full", 32'(bus.level_o), 16);
    chk("t4_ovr_set", 32'(bus.ovr_o), 32'(m_ovr));
    chk("t4_head", 32'(bus.data_o), 32'(mq[0][7:0]));
    repeat (5) @(posedge clk);
    #1;
    chk("t4_head_stable", 32'(bus.data_o), 32'(mq[0][7:0]));
    send_frame(8'h11, 8, 0, 0, 0, 1, 1, 15, -1, 0, 1, 0);
    mpush(word(8'h11, 8, 0, 0, 0, 1, 1));
    chk("t4_clr_vs_drop", 32'(bus.ovr_o), 1);
    clear_ovr();
    chk("t4_ovr_cleared", 32'(bus.ovr_o), 0);
    drain("t4_drain");
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(8'h40 + i), 8, 0, 0, 0, 1, 1, 15, -1, 0, 0, 0);
      mpush(word(8'(8'h40 + i), 8, 0, 0, 0, 1, 1));
    end
    send_frame(8'h5A, 8, 0, 0, 0, 1, 1, 15, -1, 1, 0, 0);
    mpush(word(8'h5A, 8, 0, 0, 0, 1, 1));
    chk("t5_level", 32'(bus.level_o), 16);
    chk("t5_ovr", 32'(bus.ovr_o), 0);
    drain("t5_drain");
    for (int r = 0; r < 5; r++) begin
      int k;
      rdy_hold = 1'($urandom_range(0, 1));
      k = $urandom_range(3, 18);
      for (int f = 0; f < k; f++) begin
        logic [7:0] d;
        int n, par, baud;
        bit st2, pflip, s1, s2, scr;
        d     = 8'($urandom);
        n     = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(5, 8);
        par   = $urandom_range(0, 3);
        st2   = 1'($urandom);
        pflip = ($urandom_range(0, 3) == 0);
        s1    = ($urandom_range(0, 4) != 0);
        s2    = ($urandom_range(0, 4) != 0);
        baud  = $urandom_range(7, 12);
        scr   = ($urandom_range(0, 3) == 0);
        send_frame(d, n, par, st2, pflip, s1, s2, baud, -1, 0, 0, scr);
        mpush(word(d, n, par, st2, pflip, s1, s2));
        chk("rnd_level", 32'(bus.level_o), 32'(mq.size() - got.size()));
        chk("rnd_ovr", 32'(bus.ovr_o), 32'(m_ovr));
      end
      drain("rnd_drain");
      clear_ovr();
    end
    rdy_hold = 1'b0;
    send_frame(8'h77, 8, 0, 0, 0, 1, 1, 15, -1, 0, 0, 0);
    mpush(word(8'h77, 8, 0, 0, 0, 1, 1));
    chk("rst_mid_pre_level", 32'(bus.level_o), 1);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #2;
    chk("rst_mid_level", 32'(bus.level_o), 0);
    chk("rst_mid_vld", 32'(bus.vld_o), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    rx = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    got.delete();
    repeat (200) @(posedge clk);
    #1;
    chk("rst_mid_no_push", 32'(bus.vld_o), 0);
    chk("rst_mid_no_pop", 32'(got.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
